input_alignment_unpadding: RTL and testbench
============================================

Name: input_alignment_unpadding

Overview:
- Inverse of the activation padding stage on the read side: consumes padded, lane-aligned activation words, strips left/right padding lanes per row and repacks the surviving lanes into dense output words.
- Sits between activation memory readout and the PE-array input feeder.
- Uses a valid/ready handshake on both sides, a residual lane buffer and a flush state for row ends.

Parameters:
- ACT_DATA_WIDTH, 8, bits per activation lane.
- N_DIM_ARRAY, 4, lanes per word; lane 0 occupies the LSBs.
- ROW_CNT_WIDTH, 8, width of the per-row input word counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- reinitialize_unpadding  in  1  synchronous clear of all state.
- skip_lanes_left  in  3  lanes dropped from the first word of a row.
- skip_lanes_right  in  3  lanes dropped from the last word of a row.
- row_words  in  ROW_CNT_WIDTH  input words per row; must be at least 1.
- input_word  in  N_DIM_ARRAY*ACT_DATA_WIDTH  padded input word (signed).
- input_valid  in  1  input word present.
- input_ready  out  1  input word accepted when valid&ready.
- output_word  out  N_DIM_ARRAY*ACT_DATA_WIDTH  packed output word (signed).
- output_lane_mask  out  N_DIM_ARRAY  bit k set means lane k is valid.
- output_last  out  1  word carries the final lane of a row.
- output_valid  out  1  output word present.
- output_ready  in  1  downstream accepts.

Behaviour:
- Reset values: output_word 0, output_lane_mask 0, output_last 0, output_valid 0. Residual count is 0, word counter is 0, state is RUN.
- Row configuration (skip_lanes_left, skip_lanes_right, row_words) is latched on the first accepted word of each row. Changes mid-row are ignored.
- Contributing lanes per accepted word:
  - First word of a row: lanes at or above skip_lanes_left.
  - Last word of a row: lanes below N_DIM_ARRAY-skip_lanes_right.
  - Single-word row (row_words=1): both rules apply.
  - Surviving lanes keep their relative order.
- Residual buffer holds 0..N_DIM_ARRAY-1 lanes at the low positions. New lanes are appended above the residual. T = residual count + new lane count.
- Non-last word:
  - If T >= N_DIM_ARRAY: emit the low N lanes with mask all-ones; the remainder becomes the new residual.
  - Otherwise: store all lanes in the residual and emit nothing.
- Last word of a row:
  - If 1 <= T <= N: emit one word with mask of T low bits and output_last=1; residual cleared.
  - If T > N: emit a full word with output_last=0, go to FLUSH, then emit the remaining T-N lanes with output_last=1. Return to RUN once that word is accepted.
  - If T = 0: emit one word with mask 0 and output_last=1.
- States:
  - RUN: accepts input.
  - FLUSH: input_ready=0; loads the flush word into the output register when the register is free.
- Output register is single-entry. Latency from an accepted input to output_valid is 1 cycle.
- input_ready = (!output_valid | output_ready) & (state==RUN) & !reinitialize_unpadding.
- While output_valid=1 and output_ready=0, all output signals hold stable.
- Word counter wraps to 0 after the last word of a row. The next accepted word starts a new row.
- reinitialize_unpadding has priority over all other inputs:
  - Clears residual, counter, state and output_valid.
  - A pending unaccepted output word is dropped.
  - Input is not accepted in that cycle.
- Asynchronous reset mid-row behaves the same as reinitialize, taking effect immediately.

Optional Feature:
- Macro: UNPAD_ZERO_FILL_EN.
- Defined: output lanes with mask bit 0 are driven to 0.
- Undefined: those lanes carry unspecified stale data. Checkers compare masked lanes only.

Test Plan:
- Pass-through. skip 0/0, row_words=2, inputs 0x04030201, 0x08070605 -> outputs 0x04030201 (mask 0xF, last=0), then 0x08070605 (mask 0xF, last=1), each 1 cycle after acceptance.
- Left skip with flush. skip_lanes_left=1, skip_lanes_right=0, row_words=2, same inputs -> no output after the first word. Then 0x05040302 (mask 0xF, last=0), then 0x__080706 (mask 0x7, last=1). input_ready is 0 for the FLUSH cycle.
- Empty row. skip 2/2, row_words=1, input 0xAABBCCDD -> one word with mask 0x0 and last=1; with UNPAD_ZERO_FILL_EN, output_word=0.
- Backpressure. Pass-through config with output_ready held 0 for 3 cycles after the first output -> output_word/mask/last stable, input_ready=0, no input lost. The second word follows 1 cycle after ready rises.
- Reinitialize. Assert reinitialize_unpadding after the first word of the left-skip row (3 lanes in residual) -> output_valid=0 next cycle. A following pass-through row reproduces the pass-through results exactly.
- Asynchronous reset. Drop reset between clock edges while output_valid=1 -> outputs go to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/input_alignment_unpadding.sv
// Strips per-row left/right padding lanes from lane-aligned activation words and repacks
// the surviving lanes densely. Optional build macro UNPAD_ZERO_FILL_EN zeroes masked-off lanes.
module input_alignment_unpadding #(
  parameter int ACT_DATA_WIDTH = 8,
  parameter int N_DIM_ARRAY    = 4,
  parameter int ROW_CNT_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reinitialize_unpadding,
  input  logic [2:0]                            skip_lanes_left,
  input  logic [2:0]                            skip_lanes_right,
  input  logic [ROW_CNT_WIDTH-1:0]              row_words,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] input_word,
  input  logic                                  input_valid,
  output logic                                  input_ready,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] output_word,
  output logic [N_DIM_ARRAY-1:0]                output_lane_mask,
  output logic                                  output_last,
  output logic                                  output_valid,
  input  logic                                  output_ready,
  output logic                                  dbg_flush
);
  // Handshake: a word moves on a rising edge where valid and ready are both high; the
  // producer holds valid and data stable until then, and ready never depends on valid.
  localparam int W  = ACT_DATA_WIDTH;
  localparam int N  = N_DIM_ARRAY;
  localparam int CW = $clog2(2 * N);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                   state_q, state_d;
  logic [W-1:0]             res_q [N];
  logic [W-1:0]             res_d [N];
  logic [CW-1:0]            res_cnt_q, res_cnt_d;
  logic [ROW_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [2:0]               skip_l_q, skip_l_d, skip_r_q, skip_r_d;
  logic [ROW_CNT_WIDTH-1:0] rw_q, rw_d;
  logic [N*W-1:0]           out_word_q, out_word_d;
  logic [N-1:0]             mask_q, mask_d;
  logic                     last_q, last_d, valid_q, valid_d;

  logic [W-1:0]             in_lane [N];
  logic [W-1:0]             comb [2*N];
  logic                     first_w, last_w, in_fire, out_free;
  logic [2:0]               eff_skip_l, eff_skip_r;
  logic [ROW_CNT_WIDTH-1:0] eff_rw;
  int                       lo_i, hi_i, new_cnt, total;

  assign out_free    = !valid_q || output_ready;
  assign input_ready = out_free && (state_q == ST_RUN) && !reinitialize_unpadding;
  assign in_fire     = input_valid && input_ready;

  always_comb begin
    first_w    = (word_cnt_q == '0);
    eff_skip_l = first_w ? skip_lanes_left  : skip_l_q;
    eff_skip_r = first_w ? skip_lanes_right : skip_r_q;
    eff_rw     = first_w ? row_words        : rw_q;
    last_w     = (word_cnt_q == eff_rw - ROW_CNT_WIDTH'(1));

    // Surviving lanes of this word form the contiguous range [lo_i, hi_i).
    lo_i = first_w ? int'(eff_skip_l) : 0;
    if (lo_i > N) lo_i = N;
    hi_i = last_w ? (N - int'(eff_skip_r)) : N;
    if (hi_i < 0) hi_i = 0;
    new_cnt = (hi_i > lo_i) ? (hi_i - lo_i) : 0;
    total   = int'(res_cnt_q) + new_cnt;

    for (int k = 0; k < N; k++) in_lane[k] = input_word[k*W +: W];

    for (int i = 0; i < 2*N; i++) begin
`ifdef UNPAD_ZERO_FILL_EN
      comb[i] = '0;
`else
      comb[i] = in_lane[i % N];
`endif
      if (i < int'(res_cnt_q)) begin
        comb[i] = res_q[i % N];
      end else begin
        for (int k = 0; k < N; k++)
          if (k >= lo_i && k < hi_i && i == int'(res_cnt_q) + k - lo_i) comb[i] = in_lane[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    res_cnt_d  = res_cnt_q;
    word_cnt_d = word_cnt_q;
    skip_l_d   = skip_l_q;
    skip_r_d   = skip_r_q;
    rw_d       = rw_q;
    out_word_d = out_word_q;
    mask_d     = mask_q;
    last_d     = last_q;
    valid_d    = valid_q;

    if (output_ready) valid_d = 1'b0;

    if (reinitialize_unpadding) begin
      state_d    = ST_RUN;
      res_cnt_d  = '0;
      word_cnt_d = '0;
      valid_d    = 1'b0;
    end else if (state_q == ST_FLUSH) begin
      if (out_free) begin
        for (int k = 0; k < N; k++) begin
          out_word_d[k*W +: W] = res_q[k];
          mask_d[k]            = (k < int'(res_cnt_q));
        end
        last_d    = 1'b1;
        valid_d   = 1'b1;
        res_cnt_d = '0;
        state_d   = ST_RUN;
      end
    end else if (in_fire) begin
      if (first_w) begin
        skip_l_d = skip_lanes_left;
        skip_r_d = skip_lanes_right;
        rw_d     = row_words;
      end
      word_cnt_d = last_w ? '0 : word_cnt_q + ROW_CNT_WIDTH'(1);
      if (last_w || total >= N) begin
        // Emit the low lanes; anything above N becomes the residual (or the flush word).
        for (int k = 0; k < N; k++) begin
          out_word_d[k*W +: W] = comb[k];
          mask_d[k]            = (k < total);
          res_d[k]             = comb[k+N];
        end
        valid_d   = 1'b1;
        last_d    = last_w && (total <= N);
        res_cnt_d = (total > N) ? CW'(total - N) : '0;
        if (last_w && total > N) state_d = ST_FLUSH;
      end else begin
        for (int k = 0; k < N; k++) res_d[k] = comb[k];
        res_cnt_d = CW'(total);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      for (int k = 0; k < N; k++) res_q[k] <= '0;
      res_cnt_q  <= '0;
      word_cnt_q <= '0;
      skip_l_q   <= '0;
      skip_r_q   <= '0;
      rw_q       <= '0;
      out_word_q <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      res_cnt_q  <= res_cnt_d;
      word_cnt_q <= word_cnt_d;
      skip_l_q   <= skip_l_d;
      skip_r_q   <= skip_r_d;
      rw_q       <= rw_d;
      out_word_q <= out_word_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign output_word      = out_word_q;
  assign output_lane_mask = mask_q;
  assign output_last      = last_q;
  assign output_valid     = valid_q;
  assign dbg_flush        = (state_q == ST_FLUSH);
endmodule

// File: tb/tb_input_alignment_unpadding.sv
// Self-checking bench for input_alignment_unpadding: table-driven rows with a scoreboard
// queue, plus hand sequences for flush, backpressure, reinitialize and asynchronous reset.
module tb_input_alignment_unpadding;
  localparam logic [31:0] WA = 32'h04030201;
  localparam logic [31:0] WB = 32'h08070605;
  localparam logic [31:0] WC = 32'h0C0B0A09;

  logic        clk = 1'b0;
  logic        reset, reinit;
  logic [2:0]  skl, skr;
  logic [7:0]  rw;
  logic [31:0] in_word, out_word;
  logic        in_valid, in_ready, out_last, out_valid, out_ready, dbg_flush;
  logic [3:0]  out_mask;

  always #5 clk = ~clk;

  input_alignment_unpadding #(.ACT_DATA_WIDTH(8), .N_DIM_ARRAY(4), .ROW_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .reinitialize_unpadding(reinit),
    .skip_lanes_left(skl), .skip_lanes_right(skr), .row_words(rw),
    .input_word(in_word), .input_valid(in_valid), .input_ready(in_ready),
    .output_word(out_word), .output_lane_mask(out_mask), .output_last(out_last),
    .output_valid(out_valid), .output_ready(out_ready), .dbg_flush(dbg_flush)
  );

  typedef struct {
    logic [2:0]        sl, sr;
    logic [7:0]        rw;
    int                n_in;
    logic [2:0][31:0]  iw;
    int                n_out;
    logic [2:0][31:0]  ow;
    logic [2:0][3:0]   om;
    logic [2:0]        ol;
  } vec_t;

  vec_t        vecs [9];
  int          errors = 0, checks = 0;
  logic [31:0] exp_q [$];
  logic [3:0]  exp_mask_q [$];
  logic        exp_last_q [$];
  bit          rand_ready_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = {8{m[k]}};
    return r;
  endfunction

  task automatic push_exp(input logic [31:0] w, input logic [3:0] m, input logic l);
    exp_q.push_back(w);
    exp_mask_q.push_back(m);
    exp_last_q.push_back(l);
  endtask

  // Scoreboard monitor: sampled 2 time units after the falling edge, once inputs settle.
  logic [31:0] hold_word;
  logic [3:0]  hold_mask;
  logic        hold_last;
  bit          holding = 1'b0;
  always @(negedge clk) begin
    logic [31:0] ew, dm;
    logic [3:0]  em;
    logic        el;
    #2;
    if (!reset) begin
      holding = 1'b0;
    end else begin
      if (holding && out_valid) begin
        check("hold_word", out_word, hold_word);
        check("hold_mask", {28'h0, out_mask}, {28'h0, hold_mask});
        check("hold_last", {31'h0, out_last}, {31'h0, hold_last});
      end
      if (out_valid && out_ready) begin
        holding = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got word %h mask %h last %0d, none expected", out_word, out_mask, out_last);
        end else begin
          ew = exp_q.pop_front();
          em = exp_mask_q.pop_front();
          el = exp_last_q.pop_front();
`ifdef UNPAD_ZERO_FILL_EN
          dm = 32'hFFFF_FFFF;
`else
          dm = lane_bits(em);
`endif
          check("out_word", out_word & dm, ew & dm);
          check("out_mask", {28'h0, out_mask}, {28'h0, em});
          check("out_last", {31'h0, out_last}, {31'h0, el});
        end
      end else if (out_valid) begin
        holding   = 1'b1;
        hold_word = out_word;
        hold_mask = out_mask;
        hold_last = out_last;
      end else begin
        holding = 1'b0;
      end
    end
  end

  always @(negedge clk) if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic drive_word(input logic [2:0] l, input logic [2:0] r, input logic [7:0] w,
                            input logic [31:0] d);
    int waited = 0;
    skl = l; skr = r; rw = w; in_word = d; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: input_ready stayed %0d, required 1", in_ready);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Non-first words carry random configuration, which the design must ignore.
  task automatic drive_next(input logic [31:0] d);
    drive_word(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(1, 255)), d);
  endtask

  task automatic run_vec(input vec_t v);
    for (int j = 0; j < v.n_out; j++) push_exp(v.ow[j], v.om[j], v.ol[j]);
    for (int j = 0; j < v.n_in; j++) begin
      if (j == 0) drive_word(v.sl, v.sr, v.rw, v.iw[j]);
      else        drive_next(v.iw[j]);
    end
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 3'd0, 8'd2, 2, {32'h0, WB, WA}, 2, {32'h0, WB, WA},
                {4'h0, 4'hF, 4'hF}, 3'b010};
    vecs[1] = '{3'd1, 3'd0, 8'd2, 2, {32'h0, WB, WA}, 2, {32'h0, 32'h00080706, 32'h05040302},
                {4'h0, 4'h7, 4'hF}, 3'b010};
    vecs[2] = '{3'd2, 3'd2, 8'd1, 1, {32'h0, 32'h0, 32'hAABBCCDD}, 1, {32'h0, 32'h0, 32'h0},
                {4'h0, 4'h0, 4'h0}, 3'b001};
    vecs[3] = '{3'd0, 3'd1, 8'd1, 1, {32'h0, 32'h0, WA}, 1, {32'h0, 32'h0, 32'h00030201},
                {4'h0, 4'h0, 4'h7}, 3'b001};
    vecs[4] = '{3'd1, 3'd1, 8'd3, 3, {WC, WB, WA}, 3, {32'h00000B0A, 32'h09080706, 32'h05040302},
                {4'h3, 4'hF, 4'hF}, 3'b100};
    vecs[5] = '{3'd3, 3'd0, 8'd2, 2, {32'h0, WB, WA}, 2, {32'h0, 32'h00000008, 32'h07060504},
                {4'h0, 4'h1, 4'hF}, 3'b010};
    vecs[6] = '{3'd0, 3'd3, 8'd2, 2, {32'h0, WB, WA}, 2, {32'h0, 32'h00000005, WA},
                {4'h0, 4'h1, 4'hF}, 3'b010};
    vecs[7] = '{3'd2, 3'd2, 8'd2, 2, {32'h0, WB, WA}, 1, {32'h0, 32'h0, 32'h06050403},
                {4'h0, 4'h0, 4'hF}, 3'b001};
    vecs[8] = '{3'd4, 3'd0, 8'd2, 2, {32'h0, WB, WA}, 1, {32'h0, 32'h0, WB},
                {4'h0, 4'h0, 4'hF}, 3'b001};

    reset = 1'b0; reinit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    skl = '0; skr = '0; rw = 8'd1; in_word = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_mask", {28'h0, out_mask}, 32'd0);
    check("rst_last", {31'h0, out_last}, 32'd0);
    check("rst_word", out_word, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Pass-through with one-cycle latency.
    push_exp(WA, 4'hF, 1'b0);
    push_exp(WB, 4'hF, 1'b1);
    drive_word(3'd0, 3'd0, 8'd2, WA);
    #1 check("lat_valid_first", {31'h0, out_valid}, 32'd1);
    @(negedge clk);
    drive_next(WB);
    #1 check("lat_valid_second", {31'h0, out_valid}, 32'd1);
    @(negedge clk);

    // Left skip: nothing after the first word, then a full word and a flush word.
    push_exp(32'h05040302, 4'hF, 1'b0);
    push_exp(32'h00080706, 4'h7, 1'b1);
    drive_word(3'd1, 3'd0, 8'd2, WA);
    #1 check("skip_no_out", {31'h0, out_valid}, 32'd0);
    @(negedge clk);
    drive_next(WB);
    #1;
    check("flush_ready_low", {31'h0, in_ready}, 32'd0);
    check("flush_state", {31'h0, dbg_flush}, 32'd1);
    @(negedge clk);
    #1;
    check("flush_ready_back", {31'h0, in_ready}, 32'd1);
    check("flush_last", {31'h0, out_last}, 32'd1);
    drain("drain_hand");

    // Backpressure: output held for three cycles, second word not lost.
    push_exp(WA, 4'hF, 1'b0);
    push_exp(WB, 4'hF, 1'b1);
    drive_word(3'd0, 3'd0, 8'd2, WA);
    out_ready = 1'b0;
    in_word = WB; skl = 3'd5; skr = 3'd6; rw = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready_low", {31'h0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_ready_high", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_second_valid", {31'h0, out_valid}, 32'd1);
    check("bp_second_word", out_word, WB);
    drain("drain_bp");

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    drain("drain_table");

    rand_ready_en = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    drain("drain_table_rand");
    rand_ready_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);

    // Reinitialize drops a pending word.
    out_ready = 1'b0;
    drive_word(3'd0, 3'd0, 8'd2, WA);
    #1 check("pend_valid", {31'h0, out_valid}, 32'd1);
    @(negedge clk) reinit = 1'b1;
    @(negedge clk) reinit = 1'b0;
    out_ready = 1'b1;
    #1 check("reinit_drop", {31'h0, out_valid}, 32'd0);
    @(negedge clk);

    // Reinitialize with three lanes in the residual mid-row.
    drive_word(3'd1, 3'd0, 8'd2, WA);
    reinit = 1'b1;
    #1 check("reinit_ready", {31'h0, in_ready}, 32'd0);
    @(negedge clk) reinit = 1'b0;
    #1 check("reinit_valid", {31'h0, out_valid}, 32'd0);
    @(negedge clk);
    run_vec(vecs[0]);
    drain("drain_reinit");

    // Asynchronous reset between edges while a word is pending.
    out_ready = 1'b0;
    drive_word(3'd0, 3'd0, 8'd2, WA);
    #1 check("async_pre_valid", {31'h0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_valid", {31'h0, out_valid}, 32'd0);
    check("async_mask", {28'h0, out_mask}, 32'd0);
    check("async_last", {31'h0, out_last}, 32'd0);
    check("async_word", out_word, 32'd0);
    @(negedge clk) reset = 1'b1;
    out_ready = 1'b1;
    run_vec(vecs[4]);
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
